// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  // Fetch FSM: waiting on memory, holding an instruction, or discarding a stale fetch.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory, decode handoff and execute redirect.
interface mips_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              misalign_pulse;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_out, pc_plus4, misalign_pulse,
    input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_target
  );

  // Memory / decode / execute side.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_out, pc_plus4, misalign_pulse,
    output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/mips_pc_reg.sv
// Program counter: redirect load (word-masked) beats increment beats hold.
module mips_pc_reg
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-3:0] load_word,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;

  // Select the next PC; the increment wraps modulo 2^ADDR_W.
  always_comb begin
    pc_next_s = pc_r;
    if (load) begin
      pc_next_s = {load_word, 2'b00};
    end else if (inc) begin
      pc_next_s = pc_r + ADDR_W'(PC_INC);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc      = pc_r;
  assign pc_next = pc_next_s;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC ownership, memory req/ack, decode valid/ready, redirects.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  mips_fetch_unit_if.master bus
);

  fetch_state_t      state_r, next_state_s;
  logic              req_r, req_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic [DATA_W-1:0] inst_r;
  logic [ADDR_W-1:0] pc_out_r, pc_plus4_r;
  logic              misalign_r, misalign_nxt_s;
  logic              ack_s, capture_s;
  logic [ADDR_W-1:0] pc_s, pc_next_s;

  mips_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.redirect_valid),
    .load_word (bus.redirect_target[ADDR_W-1:2]),
    .inc       (capture_s),
    .pc        (pc_s),
    .pc_next   (pc_next_s)
  );

  // An ack only counts while our own request is actually on the bus.
  assign ack_s = bus.imem_ack && req_r && ((state_r == S_REQ) || (state_r == S_DRAIN));

  // Next-state and next-output logic; redirect outranks every other event.
  always_comb begin
    next_state_s   = state_r;
    capture_s      = 1'b0;
    valid_nxt_s    = valid_r;
    misalign_nxt_s = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
    case (state_r)
      S_REQ: begin
        if (bus.redirect_valid) begin
          next_state_s = ack_s ? S_REQ : S_DRAIN;
        end else if (ack_s) begin
          next_state_s = S_VALID;
          capture_s    = 1'b1;
        end else begin
          next_state_s = S_REQ;
        end
      end
      S_VALID: begin
        if (bus.redirect_valid || bus.inst_ready) begin
          next_state_s = S_REQ;
        end else begin
          next_state_s = S_VALID;
        end
      end
      S_DRAIN: begin
        if (bus.redirect_valid) begin
          next_state_s = S_DRAIN;
        end else if (ack_s) begin
          next_state_s = S_REQ;
        end else begin
          next_state_s = S_DRAIN;
        end
      end
      default: begin
        next_state_s = S_REQ;
      end
    endcase
    if (bus.redirect_valid) begin
      valid_nxt_s = 1'b0;
    end else if (capture_s) begin
      valid_nxt_s = 1'b1;
    end else if ((state_r == S_VALID) && bus.inst_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
    req_nxt_s = (next_state_s == S_REQ) || (next_state_s == S_DRAIN);
    // A draining request keeps its original address until memory answers it.
    if (next_state_s == S_DRAIN) begin
      addr_nxt_s = addr_r;
    end else begin
      addr_nxt_s = pc_next_s;
    end
  end

  // FSM state and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_REQ;
      req_r      <= 1'b0;
      addr_r     <= RESET_PC;
      valid_r    <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      req_r      <= req_nxt_s;
      addr_r     <= addr_nxt_s;
      valid_r    <= valid_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

  // Decode-side payload, captured only on an accepted fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_r     <= DATA_W'(NOP_INST);
      pc_out_r   <= {ADDR_W{1'b0}};
      pc_plus4_r <= {ADDR_W{1'b0}};
    end else if (capture_s) begin
      inst_r     <= bus.imem_rdata;
      pc_out_r   <= pc_s;
      pc_plus4_r <= pc_s + ADDR_W'(PC_INC);
    end else begin
      inst_r     <= inst_r;
      pc_out_r   <= pc_out_r;
      pc_plus4_r <= pc_plus4_r;
    end
  end

  assign bus.imem_req       = req_r;
  assign bus.imem_addr      = addr_r;
  assign bus.inst_valid     = valid_r;
  assign bus.inst_out       = inst_r;
  assign bus.pc_out         = pc_out_r;
  assign bus.pc_plus4       = pc_plus4_r;
  assign bus.misalign_pulse = misalign_r;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed testbench for mips_fetch_unit: main unit at RESET_PC=0, second unit for PC wrap.
`timescale 1ns/1ps
module tb_mips_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   lat = 0;
  logic force_ack = 1'b0;
  logic [3:0] wait_cnt = 4'd0;
  logic ready2 = 1'b0;

  always #5 clk = ~clk;

  mips_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mips_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  mips_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  mips_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2008_0005;
      32'h0000_0004: mem_word = 32'h2009_000A;
      default:       mem_word = 32'hC000_0000 | a;
    endcase
  endfunction

  // Memory model: ack once the request has waited 'lat' cycles.
  always_ff @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wait_cnt <= 4'd0;
    else wait_cnt <= wait_cnt + 4'd1;
  end
  assign bus.imem_ack   = force_ack | (bus.imem_req && (int'(wait_cnt) >= lat));
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  assign bus2.imem_ack        = bus2.imem_req;
  assign bus2.imem_rdata      = 32'h1234_5678;
  assign bus2.inst_ready      = ready2;
  assign bus2.redirect_valid  = 1'b0;
  assign bus2.redirect_target = 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst_out, 32'h0000_0000);
    chk("rst_pc4", bus.pc_plus4, 32'h0000_0000);
    chk("rst_mis", {31'd0, bus.misalign_pulse}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0000_0000);
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    chk("zw0_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("zw0_inst", bus.inst_out, 32'h2008_0005);
    chk("zw0_pc", bus.pc_out, 32'h0000_0000);
    chk("zw0_pc4", bus.pc_plus4, 32'h0000_0004);
    chk("zw0_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("zw_gap_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("zw1_addr", bus.imem_addr, 32'h0000_0004);
    @(negedge clk);
    chk("zw1_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("zw1_inst", bus.inst_out, 32'h2009_000A);
    chk("zw1_pc", bus.pc_out, 32'h0000_0004);
  endtask

  task automatic test_backpressure();
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("bp_inst", bus.inst_out, 32'h2009_000A);
      chk("bp_pc", bus.pc_out, 32'h0000_0004);
      chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
    end
    lat = 3;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_req", {31'd0, bus.imem_req}, 32'd1);
    chk("bp_rel_addr", bus.imem_addr, 32'h0000_0008);
    chk("bp_rel_valid", {31'd0, bus.inst_valid}, 32'd0);
  endtask

  task automatic test_redirect_drain();
    logic seen;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0000_0040;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_addr", bus.imem_addr, 32'h0000_0008);
      chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
      chk("drain_valid", {31'd0, bus.inst_valid}, 32'd0);
      if (bus.imem_ack) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain_ack_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("redir_req", {31'd0, bus.imem_req}, 32'd1);
    chk("redir_addr", bus.imem_addr, 32'h0000_0040);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.inst_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("redir_valid_seen", {31'd0, seen}, 32'd1);
    chk("redir_inst", bus.inst_out, 32'hC000_0040);
    chk("redir_pc", bus.pc_out, 32'h0000_0040);
  endtask

  task automatic test_redirect_misalign();
    lat = 0;
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.inst_ready = 1'b0;
    chk("mis_pulse", {31'd0, bus.misalign_pulse}, 32'd1);
    chk("mis_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("mis_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mis_addr", bus.imem_addr, 32'h0000_0100);
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, bus.misalign_pulse}, 32'd0);
    chk("mis_f_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("mis_f_pc", bus.pc_out, 32'h0000_0100);
    chk("mis_f_pc4", bus.pc_plus4, 32'h0000_0104);
    chk("mis_f_inst", bus.inst_out, 32'hC000_0100);
  endtask

  task automatic test_async_reset();
    lat = 5;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    chk("ar_wait_req", {31'd0, bus.imem_req}, 32'd1);
    chk("ar_wait_addr", bus.imem_addr, 32'h0000_0104);
    chk("ar_wait_pc", bus.pc_out, 32'h0000_0100);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", {31'd0, bus.imem_req}, 32'd0);
    chk("ar_inst", bus.inst_out, 32'h0000_0000);
    chk("ar_pc", bus.pc_out, 32'h0000_0000);
    chk("ar_pc4", bus.pc_plus4, 32'h0000_0000);
    chk("ar_addr", bus.imem_addr, 32'h0000_0000);
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("ar_stale_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    force_ack = 1'b0;
    lat = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("ar_rel_req", {31'd0, bus.imem_req}, 32'd1);
    chk("ar_rel_addr", bus.imem_addr, 32'h0000_0000);
  endtask

  task automatic test_wrap();
    chk("wr_req", {31'd0, bus2.imem_req}, 32'd1);
    chk("wr_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr_valid", {31'd0, bus2.inst_valid}, 32'd1);
    chk("wr_pc", bus2.pc_out, 32'hFFFF_FFFC);
    chk("wr_pc4", bus2.pc_plus4, 32'h0000_0000);
    chk("wr_inst", bus2.inst_out, 32'h1234_5678);
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    chk("wr_next_req", {31'd0, bus2.imem_req}, 32'd1);
    chk("wr_next_addr", bus2.imem_addr, 32'h0000_0000);
  endtask

  initial begin
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0000_0000;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_drain();
    test_redirect_misalign();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
